nrs_est_time_interp: RTL

- Reader/consumer side of the NRS pilot-estimate store in the channel-estimation chain.
- Reads the four stored pilot estimates for one slot. Entries 0/1 are the two pilots at OFDM symbol L_A; entries 2/3 are the two pilots at symbol L_B.
- Averages each pilot pair, then linearly inter/extrapolates in time.
- Streams one complex channel estimate per OFDM symbol (0..NUM_SYM-1) to the equalizer over a valid/ready handshake.

---
 rtl/nrs_est_time_interp_if.sv | 36 +++
 rtl/nrs_est_time_interp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nrs_est_time_interp_if.sv
// Store-read and estimate-stream bundle for nrs_est_time_interp.
// The master modport is the interpolator side; slave is the store plus equalizer side.
interface nrs_est_time_interp_if #(
    parameter int WIDTH_EST = 17
);
    logic        [1:0]           rd_addr;
    logic signed [WIDTH_EST-1:0] est_r;
    logic signed [WIDTH_EST-1:0] est_i;
    logic signed [WIDTH_EST-1:0] h_r;
    logic signed [WIDTH_EST-1:0] h_i;
    logic                        h_valid;
    logic                        h_ready;
    logic        [2:0]           sym_idx;

    modport master (
        output rd_addr,
        input  est_r,
        input  est_i,
        output h_r,
        output h_i,
        output h_valid,
        input  h_ready,
        output sym_idx
    );

    modport slave (
        input  rd_addr,
        output est_r,
        output est_i,
        input  h_r,
        input  h_i,
        input  h_valid,
        output h_ready,
        input  sym_idx
    );
endinterface

// File: rtl/nrs_est_time_interp.sv
// Reads the four NRS pilot estimates of a slot, averages each pilot pair and streams a linear
// time inter/extrapolation for every OFDM symbol. Define NRS_INTERP_ROUND_EN for round-half-up pair averages.
module nrs_est_time_interp #(
    parameter int WIDTH_EST = 17,
    parameter int NUM_SYM   = 7,
    parameter int L_A       = 5,
    parameter int L_B       = 6,
    parameter int ACC_W     = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    nrs_est_time_interp_if.master  bus
);

    localparam int SUM_W = WIDTH_EST + 1;
    localparam logic [1:0] LAST_ADDR = 2'd3;
    localparam logic [2:0] LAST_SYM  = 3'(NUM_SYM - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (WIDTH_EST - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

`ifdef NRS_INTERP_ROUND_EN
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(1);
`else
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(0);
`endif

    // The per-symbol step equals one pair-to-pair delta only when the pilot symbols are adjacent.
    if (L_B != L_A + 1) begin : g_bad_pilot_spacing
        $error("nrs_est_time_interp: L_B must equal L_A+1");
    end

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        STREAM,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic start_read;
    logic capture;
    logic load;
    logic step;

    logic        [1:0]           rd_addr_q;
    logic        [2:0]           sym_q;
    logic signed [WIDTH_EST-1:0] cap_r_q [4];
    logic signed [WIDTH_EST-1:0] cap_i_q [4];
    logic signed [ACC_W-1:0]     acc_r_q;
    logic signed [ACC_W-1:0]     acc_i_q;
    logic signed [ACC_W-1:0]     dlt_r_q;
    logic signed [ACC_W-1:0]     dlt_i_q;

    function automatic logic signed [SUM_W-1:0] pair_avg(
        input logic signed [WIDTH_EST-1:0] a,
        input logic signed [WIDTH_EST-1:0] b
    );
        logic signed [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b) + RND;
        return s >>> 1;
    endfunction

    function automatic logic signed [WIDTH_EST-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[WIDTH_EST-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[WIDTH_EST-1:0];
        end else begin
            return v[WIDTH_EST-1:0];
        end
    endfunction

    logic signed [SUM_W-1:0] avg_a_r;
    logic signed [SUM_W-1:0] avg_b_r;
    logic signed [SUM_W-1:0] avg_a_i;
    logic signed [SUM_W-1:0] avg_b_i;
    logic signed [SUM_W-1:0] dlt_r;
    logic signed [SUM_W-1:0] dlt_i;
    logic signed [ACC_W-1:0] init_r;
    logic signed [ACC_W-1:0] init_i;

    assign avg_a_r = pair_avg(cap_r_q[0], cap_r_q[1]);
    assign avg_b_r = pair_avg(cap_r_q[2], cap_r_q[3]);
    assign avg_a_i = pair_avg(cap_i_q[0], cap_i_q[1]);
    assign avg_b_i = pair_avg(cap_i_q[2], cap_i_q[3]);
    assign dlt_r   = avg_b_r - avg_a_r;
    assign dlt_i   = avg_b_i - avg_a_i;

    // Extrapolate back from symbol L_A to symbol 0; ACC_W leaves headroom for the full sweep.
    assign init_r = ACC_W'(avg_a_r) - ACC_W'(L_A) * ACC_W'(dlt_r);
    assign init_i = ACC_W'(avg_a_i) - ACC_W'(L_A) * ACC_W'(dlt_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        start_read = 1'b0;
        capture    = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_read = 1'b1;
                    state_d    = READ;
                end
            end
            READ: begin
                capture = 1'b1;
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                load    = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (bus.h_ready) begin
                    step = 1'b1;
                    if (sym_q == LAST_SYM) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q <= '0;
            sym_q     <= '0;
            acc_r_q   <= '0;
            acc_i_q   <= '0;
            dlt_r_q   <= '0;
            dlt_i_q   <= '0;
            // NOTE: the capture array is only four entries, so it is cleared with the rest of the
            // state; larger storage would normally be left unreset to map onto RAM.
            for (int k = 0; k < 4; k++) begin
                cap_r_q[k] <= '0;
                cap_i_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            if (start_read) begin
                rd_addr_q <= '0;
            end else if (capture) begin
                cap_r_q[rd_addr_q] <= bus.est_r;
                cap_i_q[rd_addr_q] <= bus.est_i;
                rd_addr_q          <= rd_addr_q + 2'd1;
            end

            if (load) begin
                acc_r_q <= init_r;
                acc_i_q <= init_i;
                dlt_r_q <= ACC_W'(dlt_r);
                dlt_i_q <= ACC_W'(dlt_i);
                sym_q   <= '0;
            end else if (step) begin
                acc_r_q <= acc_r_q + dlt_r_q;
                acc_i_q <= acc_i_q + dlt_i_q;
                sym_q   <= sym_q + 3'd1;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign bus.rd_addr = rd_addr_q;
    assign bus.h_valid = (state_q == STREAM);
    assign bus.sym_idx = sym_q;
    assign bus.h_r     = sat(acc_r_q);
    assign bus.h_i     = sat(acc_i_q);

endmodule
